tx_fire_pulse_generator: RTL and testbench

- Per-channel phase-delayed transducer pulse generator, directly downstream of the output control sequencer.
- On a one-cycle fire strobe it latches eight 16-bit phase delays and a charge time, then drives each channel high for the charge time, starting at its own delay.
- Produces the 8-bit transducer_specifiedOutput that the sequencer ANDs with its channel mask.
- Carries its own over-charge watchdog, which raises the danger/kill line.

---
 rtl/tx_pkg.sv | 26 ++
 rtl/tx_channel_pulser.sv | 50 +++++
 rtl/tx_fire_pulse_generator.sv | 143 ++++++++++++++
 tb/tb_tx_fire_pulse_generator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared constants, FSM encoding and charge-time clamp for the transmit pulse generator.
package tx_pkg;

    localparam int unsigned NCH    = 8;   // transducer channels
    localparam int unsigned DLY_W  = 16;  // phase delay width in txCLK cycles
    localparam int unsigned CT_W   = 9;   // charge time width
    localparam int unsigned CT_MAX = 500; // hard ceiling on charge time

    // Counter is one bit wider than a delay so delay + charge time never overflows.
    localparam int unsigned CNT_W  = DLY_W + 1;
    // Per-channel high-time watchdog width.
    localparam int unsigned WD_W   = 10;

    typedef logic [1:0] fire_state_t;
    localparam fire_state_t IDLE = 2'd0;
    localparam fire_state_t RUN  = 2'd1;
    localparam fire_state_t DONE = 2'd2;

    function automatic logic [CT_W-1:0] clamp_ct(input logic [CT_W-1:0] ct);
        if (ct > CT_W'(CT_MAX)) begin
            return CT_W'(CT_MAX);
        end
        return ct;
    endfunction

endpackage

// File: rtl/tx_channel_pulser.sv
// One transducer channel: registered drive window [delay, delay + ct_eff) plus an
// over-charge watchdog that counts consecutive high cycles.
module tx_channel_pulser
    import tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] counter,
    input  logic [DLY_W-1:0] delay,
    input  logic [CT_W-1:0]  ct_eff,
    input  logic             run,
    input  logic             kill,
    output logic             drive,
    output logic             finished,
    output logic             wd_trip
);

    logic [CNT_W-1:0] pulse_end;
    logic             drive_d;
    logic [WD_W-1:0]  wd_q;
    logic [WD_W-1:0]  wd_d;

    // Window decode; a zero charge time finishes immediately regardless of delay.
    always_comb begin
        pulse_end = {1'b0, delay} + CNT_W'(ct_eff);
        finished  = (ct_eff == '0) || (counter >= pulse_end);
        drive_d   = run && !kill && (counter >= CNT_W'(delay)) && (counter < pulse_end);
    end

    // Watchdog counts high cycles, saturating, and restarts whenever the drive is low.
    always_comb begin
        wd_d = '0;
        if (drive) begin
            wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
        end
        wd_trip = (wd_q > WD_W'(CT_MAX));
    end

    // Drive and watchdog state; reset drops the drive asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive <= 1'b0;
            wd_q  <= '0;
        end else begin
            drive <= drive_d;
            wd_q  <= wd_d;
        end
    end

endmodule

// File: rtl/tx_fire_pulse_generator.sv
// Phase-delayed transducer pulse generator: latches per-channel delays and a clamped
// charge time on a fire strobe, runs a shared cycle counter, and raises a sticky
// danger flag if any channel stays high too long.
module tx_fire_pulse_generator
    import tx_pkg::*;
(
    input  logic                 txCLK,
    input  logic                 txRST_n,
    input  logic                 itxFire,
    input  logic [NCH*DLY_W-1:0] itxPhaseDelays,
    input  logic [CT_W-1:0]      itxChargeTime,
    input  logic                 itxAbort,
    input  logic                 itxClearDanger,
    output logic [NCH-1:0]       otxPulseOutput,
    output logic                 otxBusy,
    output logic                 otxDone,
    output logic                 otxFireRejected,
    output logic                 otxDanger
);

    fire_state_t          state_q, state_d;
    logic [CNT_W-1:0]     counter_q, counter_d;
    logic [NCH*DLY_W-1:0] delays_q, delays_d;
    logic [CT_W-1:0]      ct_q, ct_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rej_q, rej_d;
    logic                 danger_q, danger_d;

    logic [NCH-1:0]       finished;
    logic [NCH-1:0]       trip;
    logic                 all_fin;
    logic                 any_trip;
    logic                 kill;
    logic                 run;
    logic                 accept;

    // Abort and a watchdog trip both force every channel low on the next edge.
    always_comb begin
        all_fin  = &finished;
        any_trip = |trip;
        kill     = itxAbort || any_trip;
        run      = (state_q == RUN);
        accept   = itxFire && !kill && (state_q == IDLE) && !danger_q;
        // A fire dropped by abort is not reported as rejected.
        rej_d    = itxFire && !itxAbort && ((state_q != IDLE) || danger_q);
    end

    // Sequencer next-state: abort/trip first, then the IDLE -> RUN -> DONE walk.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        delays_d  = delays_q;
        ct_d      = ct_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (kill) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        delays_d  = itxPhaseDelays;
                        ct_d      = clamp_ct(itxChargeTime);
                        counter_d = '0;
                        busy_d    = 1'b1;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    counter_d = (counter_q == '1) ? counter_q : counter_q + 1'b1;
                    if (all_fin) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sticky danger: a trip sets it even if a clear arrives in the same cycle.
    always_comb begin
        danger_d = danger_q;
        if (any_trip) begin
            danger_d = 1'b1;
        end else if (itxClearDanger) begin
            danger_d = 1'b0;
        end
    end

    // Sequencer registers.
    always_ff @(posedge txCLK or negedge txRST_n) begin
        if (!txRST_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            delays_q  <= '0;
            ct_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rej_q     <= 1'b0;
            danger_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            delays_q  <= delays_d;
            ct_q      <= ct_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rej_q     <= rej_d;
            danger_q  <= danger_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        tx_channel_pulser u_ch (
            .clk      (txCLK),
            .rst_n    (txRST_n),
            .counter  (counter_q),
            .delay    (delays_q[k*DLY_W +: DLY_W]),
            .ct_eff   (ct_q),
            .run      (run),
            .kill     (kill),
            .drive    (otxPulseOutput[k]),
            .finished (finished[k]),
            .wd_trip  (trip[k])
        );
    end

    assign otxBusy         = busy_q;
    assign otxDone         = done_q;
    assign otxFireRejected = rej_q;
    assign otxDanger       = danger_q;

endmodule

// File: tb/tb_tx_fire_pulse_generator.sv
// Directed bench: expected per-cycle output words are queued when a fire is driven,
// then popped and compared one cycle at a time.
module tb_tx_fire_pulse_generator;

    logic         txCLK = 1'b0;
    logic         txRST_n;
    logic         itxFire;
    logic [127:0] itxPhaseDelays;
    logic [8:0]   itxChargeTime;
    logic         itxAbort;
    logic         itxClearDanger;
    logic [7:0]   otxPulseOutput;
    logic         otxBusy;
    logic         otxDone;
    logic         otxFireRejected;
    logic         otxDanger;

    typedef struct packed {
        logic [7:0] pulse;
        logic       busy;
        logic       done;
        logic       rej;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    tx_fire_pulse_generator dut (
        .txCLK           (txCLK),
        .txRST_n         (txRST_n),
        .itxFire         (itxFire),
        .itxPhaseDelays  (itxPhaseDelays),
        .itxChargeTime   (itxChargeTime),
        .itxAbort        (itxAbort),
        .itxClearDanger  (itxClearDanger),
        .otxPulseOutput  (otxPulseOutput),
        .otxBusy         (otxBusy),
        .otxDone         (otxDone),
        .otxFireRejected (otxFireRejected),
        .otxDanger       (otxDanger)
    );

    always #5 txCLK = ~txCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge txCLK);
        #1;
    endtask

    // Expected trace from the window formula; j counts cycles after the accepting edge.
    // cut >= 0: outputs expected low from cycle cut+1 on (abort or reset at cycle cut).
    task automatic push_trace(input logic [127:0] dv, input int ct, input int cut,
                              input int rej_j);
        int   cte;
        int   e;
        int   last;
        int   dk;
        exp_t x;
        cte = (ct > 500) ? 500 : ct;
        e = 0;
        if (cte != 0) begin
            for (int k = 0; k < 8; k++) begin
                dk = int'(dv[16*k +: 16]);
                if (dk + cte > e) e = dk + cte;
            end
        end
        last = (cut >= 0) ? cut + 3 : e + 2;
        for (int j = 0; j <= last; j++) begin
            x = '0;
            if (cut < 0 || j <= cut) begin
                x.busy = (j <= e + 1);
                x.done = (j == e + 1);
                for (int k = 0; k < 8; k++) begin
                    dk = int'(dv[16*k +: 16]);
                    x.pulse[k] = (j >= 1) && (j - 1 >= dk) && (j - 1 < dk + cte);
                end
            end
            x.rej = (j == rej_j);
            sb.push_back(x);
        end
    endtask

    task automatic fire(input logic [127:0] dv, input logic [8:0] ct);
        itxPhaseDelays = dv;
        itxChargeTime  = ct;
        itxFire        = 1'b1;
        tick();
        itxFire        = 1'b0;
    endtask

    task automatic run_sb(input string tag, input int fire_j, input int abort_j,
                          input int reset_j);
        int   j;
        exp_t x;
        exp_t obs;
        j = 0;
        while (sb.size() > 0) begin
            x   = sb.pop_front();
            obs = {otxPulseOutput, otxBusy, otxDone, otxFireRejected};
            check($sformatf("%s[%0d]", tag, j), 32'(obs), 32'(x));
            if (j == fire_j) begin
                itxPhaseDelays = '1;
                itxChargeTime  = 9'd7;
                itxFire        = 1'b1;
            end
            if (j == abort_j) itxAbort = 1'b1;
            if (j == reset_j) begin
                txRST_n = 1'b0;
                #1;
                check("async_rst_pulse", 32'(otxPulseOutput), 32'd0);
                check("async_rst_busy", 32'(otxBusy), 32'd0);
            end
            tick();
            itxFire  = 1'b0;
            itxAbort = 1'b0;
            j++;
        end
    endtask

    initial begin
        logic [127:0] dv;
        txRST_n        = 1'b0;
        itxFire        = 1'b0;
        itxPhaseDelays = '0;
        itxChargeTime  = '0;
        itxAbort       = 1'b0;
        itxClearDanger = 1'b0;
        tick();
        tick();
        check("rst_pulse", 32'(otxPulseOutput), 32'd0);
        check("rst_busy", 32'(otxBusy), 32'd0);
        check("rst_done", 32'(otxDone), 32'd0);
        check("rst_rej", 32'(otxFireRejected), 32'd0);
        check("rst_danger", 32'(otxDanger), 32'd0);
        txRST_n = 1'b1;
        tick();

        // Staggered delays 0,10,..,70 with ct=5.
        for (int k = 0; k < 8; k++) dv[16*k +: 16] = 16'(10 * k);
        push_trace(dv, 5, -1, -1);
        fire(dv, 9'd5);
        run_sb("stagger", -1, -1, -1);

        // Charge time above the ceiling is clamped to 500.
        for (int k = 0; k < 8; k++) dv[16*k +: 16] = 16'd3;
        push_trace(dv, 511, -1, -1);
        fire(dv, 9'd511);
        run_sb("clamp", -1, -1, -1);
        check("clamp_danger", 32'(otxDanger), 32'd0);

        // Zero charge time: no pulse, done one cycle after RUN entry.
        for (int k = 0; k < 8; k++) dv[16*k +: 16] = 16'($urandom_range(0, 1000));
        push_trace(dv, 0, -1, -1);
        fire(dv, 9'd0);
        run_sb("ct0", -1, -1, -1);

        // Second fire mid-pulse is rejected and does not disturb the pulse.
        dv = '0;
        push_trace(dv, 100, -1, 5);
        fire(dv, 9'd100);
        run_sb("reject", 4, -1, -1);

        // Abort at cycle 7, then an immediate new fire.
        push_trace(dv, 20, 7, -1);
        fire(dv, 9'd20);
        run_sb("abort", -1, 7, -1);
        for (int k = 0; k < 8; k++) dv[16*k +: 16] = 16'(k);
        push_trace(dv, 3, -1, -1);
        fire(dv, 9'd3);
        run_sb("post_abort", -1, -1, -1);

        // Abort and fire together in IDLE: fire dropped, no rejected strobe.
        itxPhaseDelays = '0;
        itxChargeTime  = 9'd4;
        itxFire        = 1'b1;
        itxAbort       = 1'b1;
        tick();
        itxFire  = 1'b0;
        itxAbort = 1'b0;
        check("abort_fire_busy", 32'(otxBusy), 32'd0);
        check("abort_fire_rej", 32'(otxFireRejected), 32'd0);
        tick();
        check("abort_fire_pulse", 32'(otxPulseOutput), 32'd0);

        // Reset mid-pulse, then a normal fire after release.
        dv = '0;
        push_trace(dv, 50, 5, -1);
        fire(dv, 9'd50);
        run_sb("reset", -1, -1, 5);
        txRST_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(otxBusy), 32'd0);
        check("post_rst_pulse", 32'(otxPulseOutput), 32'd0);
        for (int k = 0; k < 8; k++) dv[16*k +: 16] = 16'(2 * k);
        push_trace(dv, 4, -1, -1);
        fire(dv, 9'd4);
        run_sb("post_reset", -1, -1, -1);

        // Clearing an already-clear danger flag leaves it clear.
        itxClearDanger = 1'b1;
        tick();
        itxClearDanger = 1'b0;
        check("clear_danger", 32'(otxDanger), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
